seq_multiplier: RTL and testbench



---
 rtl/mult_div_pkg.sv | 19 +
 rtl/seq_multiplier.sv | 108 ++++++++++
 tb/tb_seq_multiplier.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared state type and default widths for the multiplier/divider pair
//
// Purpose: common definitions so the multiplier product width matches the
//          divider dividend width and products can be fed straight back.
// Contents:
//   DEVIDENT_LENGTH - divider dividend width (equals default product width)
//   DIVISOR_LENGTH  - divider divisor width (equals default operand widths)
//   state_t         - FSM state encoding (IDLE, CALC)
package mult_div_pkg;

    localparam int DEVIDENT_LENGTH = 10;
    localparam int DIVISOR_LENGTH  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - sequential unsigned shift-and-add multiplier
//
// Purpose: captures OperA/OperB on an accepted Start and computes
//          OperA*OperB over MULTIPLIER_LENGTH cycles. Product is held
//          until the next operation completes.
// Ports:
//   CLK     in  1                   rising-edge clock
//   RST     in  1                   asynchronous active-high reset
//   Start   in  1                   request strobe, sampled only in IDLE
//   OperA   in  MULTIPLICAND_LENGTH multiplicand
//   OperB   in  MULTIPLIER_LENGTH   multiplier
//   Busy    out 1                   high while a multiplication runs
//   Done    out 1                   one-cycle pulse when Product updates
//   Product out PRODUCT_LENGTH      result register
module seq_multiplier
    import mult_div_pkg::*;
#(
    parameter int MULTIPLICAND_LENGTH = DIVISOR_LENGTH,
    parameter int MULTIPLIER_LENGTH   = DIVISOR_LENGTH,
    parameter int PRODUCT_LENGTH      = MULTIPLICAND_LENGTH + MULTIPLIER_LENGTH
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           Start,
    input  logic [MULTIPLICAND_LENGTH-1:0] OperA,
    input  logic [MULTIPLIER_LENGTH-1:0]   OperB,
    output logic                           Busy,
    output logic                           Done,
    output logic [PRODUCT_LENGTH-1:0]      Product
);

    localparam int ACC_W = MULTIPLICAND_LENGTH + MULTIPLIER_LENGTH;
    localparam int CNT_W = (MULTIPLIER_LENGTH > 1) ? $clog2(MULTIPLIER_LENGTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MULTIPLIER_LENGTH - 1);

    state_t                           state_q, state_d;
    logic [MULTIPLICAND_LENGTH-1:0]   mcand_q, mcand_d;
    logic [ACC_W-1:0]                 acc_q, acc_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [PRODUCT_LENGTH-1:0]        product_q, product_d;
    logic                             done_q, done_d;

    // One shift-and-add step: the upper half gains the multiplicand when the
    // current multiplier bit (acc LSB) is set, then {carry, acc} shifts right.
    logic [MULTIPLICAND_LENGTH:0]     sum;
    logic [ACC_W:0]                   acc_wide;
    logic [ACC_W-1:0]                 acc_step;

    always_comb begin
        sum      = {1'b0, acc_q[ACC_W-1 -: MULTIPLICAND_LENGTH]}
                 + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_wide = {sum, acc_q[MULTIPLIER_LENGTH-1:0]};
        acc_step = acc_wide[ACC_W:1];
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    mcand_d = OperA;
                    acc_d   = {{MULTIPLICAND_LENGTH{1'b0}}, OperB};
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    product_d = PRODUCT_LENGTH'(acc_step);
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign Busy    = (state_q == CALC);
    assign Done    = done_q;
    assign Product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier
module tb_seq_multiplier;

    logic       CLK;
    logic       RST;
    logic       Start;
    logic [4:0] OperA;
    logic [4:0] OperB;
    logic       Busy;
    logic       Done;
    logic [9:0] Product;

    int checks;
    int passes;
    logic [9:0] exp_q[$];

    seq_multiplier dut (
        .CLK     (CLK),
        .RST     (RST),
        .Start   (Start),
        .OperA   (OperA),
        .OperB   (OperB),
        .Busy    (Busy),
        .Done    (Done),
        .Product (Product)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drives one single-cycle Start and waits (bounded) for Done.
    // lat counts sampled cycles from the accepting edge to the Done sample.
    // busy_ok is cleared if Busy was low before Done or high with Done.
    task automatic do_op(input logic [4:0] a, input logic [4:0] b,
                         output int lat, output bit busy_ok);
        @(negedge CLK);
        Start = 1'b1;
        OperA = a;
        OperB = b;
        exp_q.push_back(10'(a) * 10'(b));
        @(negedge CLK);
        Start = 1'b0;
        OperA = 5'($urandom);
        OperB = 5'($urandom);
        lat = 0;
        busy_ok = 1'b1;
        while (Done !== 1'b1 && lat < 20) begin
            if (Busy !== 1'b1) busy_ok = 1'b0;
            @(negedge CLK);
            lat++;
        end
        if (Busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        Start = 1'b0;
        OperA = '0;
        OperB = '0;
        #1;
        checks++;
        if (Busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", Busy); else passes++;
        checks++;
        if (Done !== 1'b0) $display("FAIL reset_done got=%b want=0", Done); else passes++;
        checks++;
        if (Product !== 10'd0) $display("FAIL reset_product got=%0d want=0", Product); else passes++;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_basic;
        int lat;
        bit busy_ok;
        logic [9:0] exp;
        do_op(5'd3, 5'd7, lat, busy_ok);
        checks++;
        if (lat !== 5) $display("FAIL basic_latency got=%0d want=5", lat); else passes++;
        checks++;
        if (!busy_ok) $display("FAIL basic_busy got=0 want=1"); else passes++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
        checks++;
        if (Product !== exp) $display("FAIL basic_product got=%0d want=%0d", Product, exp); else passes++;
        checks++;
        if (Product / 10'd7 !== 10'd3) $display("FAIL basic_divide got=%0d want=3", Product / 10'd7); else passes++;
    endtask

    task automatic test_extremes;
        logic [4:0] ta[4] = '{5'd31, 5'd0, 5'd25, 5'd1};
        logic [4:0] tb[4] = '{5'd31, 5'd25, 5'd0, 5'd1};
        int lat;
        bit busy_ok;
        logic [9:0] exp;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], lat, busy_ok);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
            checks++;
            if (lat !== 5) $display("FAIL extreme_latency[%0d] got=%0d want=5", i, lat); else passes++;
            checks++;
            if (!busy_ok) $display("FAIL extreme_busy[%0d] got=0 want=1", i); else passes++;
            checks++;
            if (Product !== exp) $display("FAIL extreme_product[%0d] got=%0d want=%0d", i, Product, exp); else passes++;
        end
    endtask

    task automatic test_random;
        int lat;
        bit busy_ok;
        logic [9:0] exp;
        for (int i = 0; i < 4; i++) begin
            do_op(5'($urandom), 5'($urandom), lat, busy_ok);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
            checks++;
            if (lat !== 5 || !busy_ok) $display("FAIL random_timing[%0d] got=%0d/%0b want=5/1", i, lat, busy_ok); else passes++;
            checks++;
            if (Product !== exp) $display("FAIL random_product[%0d] got=%0d want=%0d", i, Product, exp); else passes++;
        end
    endtask

    task automatic test_busy_protect;
        int n;
        int extra;
        logic [9:0] exp;
        @(negedge CLK);
        Start = 1'b1; OperA = 5'd4; OperB = 5'd7;
        exp_q.push_back(10'd4 * 10'd7);
        @(negedge CLK);
        Start = 1'b0;
        @(negedge CLK);
        Start = 1'b1; OperA = 5'd12; OperB = 5'd3;
        @(negedge CLK);
        Start = 1'b0;
        n = 0;
        while (Done !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
        checks++;
        if (Product !== exp) $display("FAIL protect_product got=%0d want=%0d", Product, exp); else passes++;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (Done === 1'b1 || Busy === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) $display("FAIL protect_no_rerun got=%0d want=0", extra); else passes++;
        checks++;
        if (Product !== exp) $display("FAIL protect_hold got=%0d want=%0d", Product, exp); else passes++;
    endtask

    task automatic test_back_to_back;
        int n;
        int t1;
        logic [9:0] exp;
        @(negedge CLK);
        Start = 1'b1; OperA = 5'd14; OperB = 5'd2;
        exp_q.push_back(10'd14 * 10'd2);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (Done !== 1'b1 && n < 20);
        t1 = n;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
        checks++;
        if (Product !== exp) $display("FAIL b2b_product1 got=%0d want=%0d", Product, exp); else passes++;
        OperA = 5'd12; OperB = 5'd3;
        exp_q.push_back(10'd12 * 10'd3);
        @(negedge CLK);
        n++;
        Start = 1'b0;
        while (Done !== 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
        checks++;
        if (Product !== exp) $display("FAIL b2b_product2 got=%0d want=%0d", Product, exp); else passes++;
        checks++;
        if (n - t1 !== 6) $display("FAIL b2b_spacing got=%0d want=6", n - t1); else passes++;
    endtask

    task automatic test_reset_mid_calc;
        int dones;
        int lat;
        bit busy_ok;
        logic [9:0] exp;
        @(negedge CLK);
        Start = 1'b1; OperA = 5'd21; OperB = 5'd1;
        @(negedge CLK);
        Start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        checks++;
        if (Busy !== 1'b0) $display("FAIL midrst_busy got=%b want=0", Busy); else passes++;
        checks++;
        if (Done !== 1'b0) $display("FAIL midrst_done got=%b want=0", Done); else passes++;
        checks++;
        if (Product !== 10'd0) $display("FAIL midrst_product got=%0d want=0", Product); else passes++;
        @(negedge CLK);
        RST = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (Done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) $display("FAIL midrst_no_done got=%0d want=0", dones); else passes++;
        checks++;
        if (Product !== 10'd0) $display("FAIL midrst_hold got=%0d want=0", Product); else passes++;
        do_op(5'd5, 5'd5, lat, busy_ok);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
        checks++;
        if (Product !== exp || lat !== 5) $display("FAIL midrst_next got=%0d/%0d want=%0d/5", Product, lat, exp); else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_random();
        test_busy_protect();
        test_back_to_back();
        test_reset_mid_calc();
        checks++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size()); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
